// File: rtl/countdown_monitor.sv
// Measures cycles from reset/ack to the next rising edge of trigger_in, with a
// MAX_WAIT timeout and a sticky overrun flag for rises that arrive while a result is pending.
module countdown_monitor #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger_in,
  input  logic       ack,
  output logic [7:0] latency,
  output logic       valid,
  output logic       timeout,
  output logic       overrun,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_DONE    = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic [7:0] latency_next;
  logic       trig_prev;
  logic       rise;

  assign rise = trigger_in & ~trig_prev;

  // Result handshake: valid (or timeout) stays high and latency stays stable
  // until ack is seen high on a clock edge; that edge retires the result and
  // restarts counting from 0. ack has no effect while no result is pending.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    latency_next = latency;
    case (state)
      ST_WAIT: begin
        if (rise) begin
          latency_next = cnt;
          state_next   = ST_DONE;
        end else if (cnt == LIMIT) begin
          state_next = ST_TIMEOUT;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      ST_DONE, ST_TIMEOUT: begin
        if (ack) begin
          state_next = ST_WAIT;
          cnt_next   = 8'd0;
        end
      end
      default: begin
        state_next = ST_WAIT;
        cnt_next   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_WAIT;
      cnt       <= 8'd0;
      trig_prev <= 1'b0;
      latency   <= 8'd0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      trig_prev <= trigger_in;
      latency   <= latency_next;
      // A rise that cannot be captured because a result is still pending.
      overrun   <= overrun | (rise & (state != ST_WAIT));
    end
  end

  assign valid     = (state == ST_DONE);
  assign timeout   = (state == ST_TIMEOUT);
  assign dbg_state = state;

endmodule

// File: tb/tb_countdown_monitor.sv
// Directed bench for countdown_monitor: three instances (default, MAX_WAIT=10,
// MAX_WAIT=6) share clock and reset; each has its own trigger and ack.
module tb_countdown_monitor;

  logic       clk;
  logic       rst;

  logic       trig_d, ack_d, val_d, to_d, ov_d;
  logic [7:0] lat_d;
  logic [1:0] st_d;

  logic       trig_t, ack_t, val_t, to_t, ov_t;
  logic [7:0] lat_t;
  logic [1:0] st_t;

  logic       trig_6, ack_6, val_6, to_6, ov_6;
  logic [7:0] lat_6;
  logic [1:0] st_6;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];

  countdown_monitor u_def (
    .clk(clk), .rst(rst), .trigger_in(trig_d), .ack(ack_d),
    .latency(lat_d), .valid(val_d), .timeout(to_d), .overrun(ov_d), .dbg_state(st_d)
  );

  countdown_monitor #(.MAX_WAIT(10)) u_to (
    .clk(clk), .rst(rst), .trigger_in(trig_t), .ack(ack_t),
    .latency(lat_t), .valid(val_t), .timeout(to_t), .overrun(ov_t), .dbg_state(st_t)
  );

  countdown_monitor #(.MAX_WAIT(6)) u_tie (
    .clk(clk), .rst(rst), .trigger_in(trig_6), .ack(ack_6),
    .latency(lat_6), .valid(val_6), .timeout(to_6), .overrun(ov_6), .dbg_state(st_6)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks: inputs change and outputs are sampled 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst    = 1'b1;
    trig_d = 1'b0; ack_d = 1'b0;
    trig_t = 1'b0; ack_t = 1'b0;
    trig_6 = 1'b0; ack_6 = 1'b0;
    exp_q.push_back(8'd4);
    exp_q.push_back(8'd3);
    exp_q.push_back(8'd4);
    exp_q.push_back(8'd0);

    // Reset state
    do_reset();
    check("rst_latency", 32'(lat_d), 0);
    check("rst_valid",   32'(val_d), 0);
    check("rst_timeout", 32'(to_d),  0);
    check("rst_overrun", 32'(ov_d),  0);
    check("rst_state",   32'(st_d),  0);

    // Source goes high after the 4th post-release edge; captured on the 5th.
    repeat (4) tick();
    check("pre_trigger_valid", 32'(val_d), 0);
    trig_d = 1'b1;
    tick();
    check("cap1_valid",   32'(val_d), 1);
    check("cap1_latency", 32'(lat_d), 32'(exp_q.pop_front()));
    check("cap1_timeout", 32'(to_d),  0);
    check("cap1_state",   32'(st_d),  1);

    // Second rise while result pending
    trig_d = 1'b0;
    tick();
    check("ovr_before", 32'(ov_d), 0);
    trig_d = 1'b1;
    tick();
    check("ovr_set",     32'(ov_d),  1);
    check("ovr_latency", 32'(lat_d), 4);
    check("ovr_valid",   32'(val_d), 1);

    // Ack with trigger held high: no new capture until trigger drops.
    ack_d = 1'b1;
    tick();
    ack_d = 1'b0;
    check("ack_valid_low", 32'(val_d), 0);
    check("ack_ovr_kept",  32'(ov_d),  1);
    tick();
    check("stuck_no_capture", 32'(val_d), 0);
    trig_d = 1'b0;
    tick();
    tick();
    check("rearm_no_capture", 32'(val_d), 0);
    trig_d = 1'b1;
    tick();
    check("rearm_valid",   32'(val_d), 1);
    check("rearm_latency", 32'(lat_d), 32'(exp_q.pop_front()));

    // Ack while waiting must not restart the count.
    ack_d  = 1'b1;
    trig_d = 1'b0;
    tick();
    ack_d = 1'b0;
    tick();
    ack_d = 1'b1;
    tick();
    ack_d = 1'b0;
    tick();
    tick();
    trig_d = 1'b1;
    tick();
    check("wait_ack_valid",   32'(val_d), 1);
    check("wait_ack_latency", 32'(lat_d), 32'(exp_q.pop_front()));

    // Mid-operation reset with trigger still high
    rst = 1'b1;
    tick();
    check("midrst_valid",   32'(val_d), 0);
    check("midrst_latency", 32'(lat_d), 0);
    check("midrst_overrun", 32'(ov_d),  0);
    rst = 1'b0;
    tick();
    check("rst_high_trig_valid",   32'(val_d), 1);
    check("rst_high_trig_latency", 32'(lat_d), 32'(exp_q.pop_front()));

    // Timeout with MAX_WAIT=10
    trig_d = 1'b0;
    trig_t = 1'b0;
    trig_6 = 1'b0;
    do_reset();
    check("to_rst", 32'(to_t), 0);
    repeat (10) tick();
    check("to_edge10", 32'(to_t), 0);
    tick();
    check("to_edge11",     32'(to_t),  1);
    check("to_valid",      32'(val_t), 0);
    check("to_latency",    32'(lat_t), 0);
    trig_t = 1'b1;
    tick();
    check("to_ovr",        32'(ov_t),  1);
    check("to_ovr_state",  32'(st_t),  2);
    ack_t  = 1'b1;
    trig_t = 1'b0;
    tick();
    ack_t = 1'b0;
    check("to_ack_clear", 32'(to_t), 0);
    tick();
    tick();
    trig_t = 1'b1;
    tick();
    check("to_restart_valid",   32'(val_t), 1);
    check("to_restart_latency", 32'(lat_t), 2);

    // Rise on the same edge that cnt reaches MAX_WAIT=6
    do_reset();
    repeat (6) tick();
    check("tie_no_timeout_yet", 32'(to_6), 0);
    trig_6 = 1'b1;
    tick();
    check("tie_valid",   32'(val_6), 1);
    check("tie_latency", 32'(lat_6), 6);
    check("tie_timeout", 32'(to_6),  0);

    // Rise on the same edge as ack: ack retires, rise only flags overrun.
    trig_6 = 1'b0;
    tick();
    trig_6 = 1'b1;
    ack_6  = 1'b1;
    tick();
    ack_6 = 1'b0;
    check("ackrise_valid",   32'(val_6), 0);
    check("ackrise_overrun", 32'(ov_6),  1);
    check("ackrise_latency", 32'(lat_6), 6);
    tick();
    check("ackrise_no_capture", 32'(val_6), 0);

    check("exp_q_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_monitor.md
COUNTDOWN_MONITOR -- requirements
Module: countdown_monitor

Interface
REQ-001 Parameter: MAX_WAIT, default 255, timeout limit in cycles; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  reset, synchronous, active-high; sampled on posedge clk.
REQ-004 Port: trigger_in  input  1  level trigger from a countdown source; synchronous to clk.
REQ-005 Port: ack  input  1  consumer acknowledge of a reported result (valid or timeout).
REQ-006 Port: latency  output  8  captured cycle count, reset edge (or ack edge) to trigger rise.
REQ-007 Port: valid  output  1  latency holds a captured result.
REQ-008 Port: timeout  output  1  no trigger rise within MAX_WAIT cycles.
REQ-009 Port: overrun  output  1  sticky: a trigger rise occurred while a result was pending.

Function
REQ-010 The block SHALL be a Moore FSM with states ST_WAIT, ST_DONE and ST_TIMEOUT; valid and timeout are decoded from state only.
REQ-011 The block SHALL register trig_prev = trigger_in on every non-reset edge in every state; rise = trigger_in & ~trig_prev.
REQ-012 The block SHALL hold an 8-bit counter cnt.
REQ-013 In ST_WAIT with no rise, cnt SHALL increment by 1 per edge; it never wraps.
REQ-014 In ST_WAIT with rise sampled, the block SHALL load latency <= cnt (pre-increment value) and go to ST_DONE.
REQ-015 In ST_WAIT with no rise and cnt == MAX_WAIT, the block SHALL go to ST_TIMEOUT; latency is unchanged.
REQ-016 If rise and cnt == MAX_WAIT occur on the same edge, rise SHALL win: ST_DONE with latency = MAX_WAIT.
REQ-017 ST_DONE SHALL assert valid=1 and hold latency; on ack=1 it SHALL go to ST_WAIT with cnt <= 0.
REQ-018 ST_TIMEOUT SHALL assert timeout=1; on ack=1 it SHALL go to ST_WAIT with cnt <= 0.
REQ-019 ack SHALL be ignored in ST_WAIT.
REQ-020 cnt SHALL hold its value in ST_DONE and ST_TIMEOUT.
REQ-021 A rise sampled in ST_DONE or ST_TIMEOUT SHALL set overrun=1 and SHALL NOT alter latency or state; this includes a rise on the same edge as ack.
REQ-022 overrun SHALL be cleared only by rst.
REQ-023 trigger_in held high SHALL produce exactly one rise; a new rise requires trigger_in low for at least one sampled edge.
REQ-024 Result latency is 1 cycle: valid rises on the clock edge after the edge at which trigger_in is first seen high.

Reset
REQ-025 rst=1 at an edge SHALL force state=ST_WAIT, cnt=0, trig_prev=0, latency=0, overrun=0.
REQ-026 Reset values of the outputs SHALL be valid=0, timeout=0, latency=0, overrun=0.
REQ-027 rst SHALL take priority over every other input in every state, including mid-count and with a pending result.
REQ-028 If trigger_in is high during rst, the first non-reset edge SHALL detect a rise with latency=0.

Verification
REQ-029 Scenario, countdown source: a source asserts trigger_in 4 edges after its reset release; release both resets together -> valid=1 one edge after trigger_in is sampled high; latency=4; timeout=0.
REQ-030 Scenario, timeout: MAX_WAIT=10, trigger_in held 0 -> timeout=1 after the 11th post-reset edge; valid=0. Then pulse ack -> timeout=0, cnt restarts at 0.
REQ-031 Scenario, boundary tie: MAX_WAIT=6, trigger_in rises so that it is sampled when cnt=6 -> ST_DONE, latency=6, timeout never asserted.
REQ-032 Scenario, overrun: after valid=1 with latency=4, toggle trigger_in 0->1 without ack -> overrun=1, latency still 4. Then ack -> valid=0, overrun stays 1 until rst.
REQ-033 Scenario, stuck high and re-arm: trigger_in stuck 1 through ack -> no second capture. Drop trigger_in for 1 cycle, raise 3 edges after ack -> latency=3.
REQ-034 Scenario, mid-operation reset: rst pulsed while valid=1 with latency=4 -> next edge valid=0, latency=0, overrun=0, counting restarts from 0.
